riot_bus_arb: RTL and testbench

RIOT_BUS_ARB -- requirements
Module: riot_bus_arb

---
 rtl/riot_bus_arb.sv | 87 ++++++++
 tb/tb_riot_bus_arb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/riot_bus_arb.sv
// riot_bus_arb: two-port arbiter sequencing single-access transactions onto a RIOT bus
module riot_bus_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic       rs_n0,
  input  logic       rs_n1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [6:0] A,
  output logic [7:0] Din,
  output logic       CS,
  output logic       CS_n,
  output logic       R_W_n,
  output logic       RS_n,
  input  logic [7:0] Dout,
  output logic       busy,
  output logic [1:0] gnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;
  state_t state;
  logic last;
  logic sel;
  always_comb sel = RR_EN ? ((req0 && req1) ? ~last : req1) : ~req0;
  assign CS_n = ~CS;
  assign busy = |gnt;
  // CS is raised only on the IDLE->ISSUE edge, so a timer write can never repeat
  always_ff @(posedge CLK)
    if (RES) begin
      state  <= IDLE;
      CS     <= 1'b0;
      R_W_n  <= 1'b1;
      RS_n   <= 1'b1;
      A      <= '0;
      Din    <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      gnt    <= '0;
      last   <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE:
          if (req0 || req1) begin
            state <= ISSUE;
            CS    <= 1'b1;
            gnt   <= sel ? 2'b10 : 2'b01;
            last  <= sel;
            A     <= sel ? addr1 : addr0;
            Din   <= sel ? wdata1 : wdata0;
            R_W_n <= ~(sel ? we1 : we0);
            RS_n  <= sel ? rs_n1 : rs_n0;
          end
        ISSUE: begin
          state <= CAPT;
          CS    <= 1'b0;
        end
        CAPT: begin
          state <= IDLE;
          ack0  <= gnt[0];
          ack1  <= gnt[1];
          if (R_W_n && gnt[0]) rdata0 <= Dout;
          if (R_W_n && gnt[1]) rdata1 <= Dout;
          gnt   <= '0;
          A     <= '0;
          Din   <= '0;
          R_W_n <= 1'b1;
          RS_n  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_riot_bus_arb.sv
// tb_riot_bus_arb: directed checks of riot_bus_arb in round-robin and fixed-priority builds
module tb_riot_bus_arb;
  logic CLK = 1'b0;
  logic RES = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, rs_n0 = 1, rs_n1 = 1;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, CS, CS_n, R_W_n, RS_n, busy;
  logic [7:0] rdata0, rdata1, Din, Dout;
  logic [6:0] A;
  logic [1:0] gnt;
  logic f_ack0, f_ack1, f_CS, f_CS_n, f_R_W_n, f_RS_n, f_busy;
  logic [7:0] f_rdata0, f_rdata1, f_Din;
  logic [7:0] f_dout = 8'h00;
  logic [6:0] f_A;
  logic [1:0] f_gnt;
  logic [7:0] mem [128];
  logic [7:0] timer;
  logic prev_cs = 1'b0;
  logic [7:0] rd;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  riot_bus_arb #(.RR_EN(1'b1)) dut (
    .CLK(CLK), .RES(RES), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .rs_n0(rs_n0), .rs_n1(rs_n1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .A(A), .Din(Din), .CS(CS), .CS_n(CS_n),
    .R_W_n(R_W_n), .RS_n(RS_n), .Dout(Dout), .busy(busy), .gnt(gnt)
  );

  riot_bus_arb #(.RR_EN(1'b0)) dut_fp (
    .CLK(CLK), .RES(RES), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .rs_n0(rs_n0), .rs_n1(rs_n1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(f_ack0), .ack1(f_ack1),
    .rdata0(f_rdata0), .rdata1(f_rdata1), .A(f_A), .Din(f_Din), .CS(f_CS), .CS_n(f_CS_n),
    .R_W_n(f_R_W_n), .RS_n(f_RS_n), .Dout(f_dout), .busy(f_busy), .gnt(f_gnt)
  );

  // RIOT model: RAM when RS_n=0, otherwise a down-counting timer loaded by a write
  always @(posedge CLK) begin
    if (CS && !R_W_n && !RS_n) mem[A] <= Din;
    if (RES) timer <= 8'h00;
    else if (CS && !R_W_n && RS_n) timer <= Din;
    else if (timer != 8'h00) timer <= timer - 8'h01;
  end
  assign Dout = RS_n ? timer : mem[A];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RES) begin
      chk("cs_pair", CS ^ CS_n, 1);
      chk("cs_run", CS & prev_cs, 0);
      chk("ack_excl", ack0 & ack1, 0);
      chk("gnt_onehot", $onehot0(gnt), 1);
      chk("fp_ack_excl", f_ack0 & f_ack1, 0);
      chk("fp_gnt_onehot", $onehot0(f_gnt), 1);
    end
    prev_cs = CS;
  end

  task automatic chk_reset();
    chk("rst_A", A, 0);
    chk("rst_Din", Din, 0);
    chk("rst_CS", CS, 0);
    chk("rst_CS_n", CS_n, 1);
    chk("rst_R_W_n", R_W_n, 1);
    chk("rst_RS_n", RS_n, 1);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
  endtask

  task automatic do_reset();
    RES = 1'b1;
    repeat (2) @(negedge CLK);
    chk_reset();
    RES = 1'b0;
  endtask

  // one transaction on port p; drives at negedge, watches for ack with a 10-cycle bound
  task automatic xfer(input int p, input logic we, input logic rs_n, input logic [6:0] a,
                      input logic [7:0] wd, output logic [7:0] r);
    int k, cs_cnt;
    logic got_ack;
    if (p == 0) begin req0 = 1; we0 = we; rs_n0 = rs_n; addr0 = a; wdata0 = wd; end
    else        begin req1 = 1; we1 = we; rs_n1 = rs_n; addr1 = a; wdata1 = wd; end
    k = 0;
    cs_cnt = 0;
    got_ack = 1'b0;
    while (!got_ack && k < 10) begin
      @(negedge CLK);
      k++;
      cs_cnt += int'(CS);
      if (k == 1) begin
        chk("issue_A", A, a);
        chk("issue_RW", R_W_n, !we);
        chk("issue_RS", RS_n, rs_n);
        chk("issue_gnt", gnt, p == 0 ? 1 : 2);
      end
      if (k == 2) chk("capt_A_hold", A, a);
      got_ack = (p == 0) ? ack0 : ack1;
    end
    req0 = 0;
    req1 = 0;
    chk("ack_latency", k, 3);
    chk("cs_cycles", cs_cnt, 1);
    chk("idle_A", A, 0);
    chk("idle_busy", busy, 0);
    r = (p == 0) ? rdata0 : rdata1;
  endtask

  initial begin
    do_reset();
    xfer(0, 1'b1, 1'b0, 7'h05, 8'hA5, rd);
    chk("p0_wr_rdata0", rd, 8'h00);
    xfer(0, 1'b0, 1'b0, 7'h05, 8'h00, rd);
    chk("p0_rd_rdata0", rd, 8'hA5);
    chk("p0_rd_rdata1_hold", rdata1, 8'h00);
    xfer(1, 1'b1, 1'b1, 7'h14, 8'h10, rd);
    chk("tmr_wr_rdata1", rd, 8'h00);
    xfer(1, 1'b0, 1'b1, 7'h04, 8'h00, rd);
    chk("tmr_rd_le", rd <= 8'h10, 1);
    chk("tmr_rd_nonzero", rd != 8'h00, 1);
    chk("tmr_rdata0_hold", rdata0, 8'hA5);
    do_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; rs_n0 = 0; rs_n1 = 0; addr0 = 7'h05; addr1 = 7'h06;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      chk("rr_ack0", ack0, k % 6 == 3);
      chk("rr_ack1", ack1, k % 6 == 0);
      if (k % 3 == 1) chk("rr_gnt", gnt, k % 6 == 1 ? 1 : 2);
      chk("fp_ack0", f_ack0, k % 3 == 0);
      chk("fp_ack1", f_ack1, 0);
      chk("fp_gnt1", f_gnt[1], 0);
    end
    req0 = 0; req1 = 0;
    chk("rr_rdata0", rdata0, 8'hA5);
    @(negedge CLK);
    // abort a write in its ISSUE cycle
    req0 = 1; we0 = 1; rs_n0 = 0; addr0 = 7'h30; wdata0 = 8'h77;
    @(negedge CLK);
    chk("abort_cs", CS, 1);
    RES = 1'b1;
    req0 = 0;
    @(negedge CLK);
    chk_reset();
    RES = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("abort_no_ack0", ack0, 0);
      chk("abort_idle", busy, 0);
    end
    xfer(0, 1'b0, 1'b0, 7'h05, 8'h00, rd);
    chk("post_abort_rd", rd, 8'hA5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
